// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable overlapping sequence detector.
// Holds the controller state encoding, the length-width derivation and the config legality rule.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    DONE
  } state_t;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w) + 1;
  endfunction

  // A run needs a non-empty pattern that fits the history and a reachable threshold.
  function automatic logic cfg_legal(input int unsigned len, input int unsigned thresh,
                                     input int unsigned pat_w);
    return (len != 0) && (len <= pat_w) && (thresh != 0);
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Config, control, serial-input and status signals of the sequence detector controller.
// The master side is the CPU/stream driver; the slave side is the controller.
interface seq_detect_ctrl_if
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  localparam int LEN_W = len_w(PAT_W);

  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [CNT_W-1:0] cfg_thresh;
  logic             start;
  logic             stop;
  logic             in;
  logic             in_valid;
  logic             irq_clr;
  logic             match;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic [CNT_W-1:0] match_cnt;
  logic             irq;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_thresh, start, stop, in, in_valid, irq_clr,
    input  match, busy, done, cfg_err, match_cnt, irq
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_thresh, start, stop, in, in_valid, irq_clr,
    output match, busy, done, cfg_err, match_cnt, irq
  );

endinterface

// File: rtl/seq_pattern_core.sv
// Shift history, fill counter and length-masked compare for the sequence detector.
// hit is high for the one cycle after the edge that shifted in a pattern-completing bit.
module seq_pattern_core
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);

  localparam logic [LEN_W-1:0] FULL = LEN_W'(PAT_W);

  logic [PAT_W-1:0] hist_reg;
  logic [PAT_W-1:0] hist_next;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill_reg;
  logic [LEN_W-1:0] fill_next;
  logic             hit_reg;
  logic             cmp_next;

  genvar gi;
  generate
    for (gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign mask[gi] = (len > LEN_W'(gi));
    end
  endgenerate

  assign hist_next = {hist_reg[PAT_W-2:0], in};
  assign fill_next = (fill_reg == FULL) ? fill_reg : fill_reg + 1'b1;
  // Compare against the post-shift history so the hit lands one edge after the completing bit.
  assign cmp_next  = (fill_next >= len) && (((hist_next ^ pattern) & mask) == '0);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      hist_reg <= '0;
      fill_reg <= '0;
      hit_reg  <= 1'b0;
    end else if (clr) begin
      hist_reg <= '0;
      fill_reg <= '0;
      hit_reg  <= 1'b0;
    end else begin
      hit_reg <= shift_en && cmp_next;
      if (shift_en) begin
        hist_reg <= hist_next;
        fill_reg <= fill_next;
      end
    end
  end

  assign hit = hit_reg;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for the programmable overlapping sequence detector:
// config registers, IDLE/ARM/RUN/DONE sequencing, match counter and sticky irq.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               arst,
  seq_detect_ctrl_if.slave  bus
);

  localparam int LEN_W = len_w(PAT_W);

  state_t           state_reg;
  state_t           state_next;
  logic [PAT_W-1:0] pattern_reg;
  logic [LEN_W-1:0] len_reg;
  logic [CNT_W-1:0] thresh_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             match_reg;
  logic             cfg_err_reg;
  logic             cfg_err_next;
  logic             irq_reg;
  logic             cfg_ok;
  logic             hit;
  logic             count_en;
  logic             thresh_hit;
  logic             idle_or_done;

  assign idle_or_done = (state_reg == IDLE) || (state_reg == DONE);
  assign cfg_ok       = cfg_legal(32'(len_reg), 32'(thresh_reg), PAT_W);
  // A pending hit is dropped if stop lands on the edge that would have counted it.
  assign count_en     = (state_reg == RUN) && !bus.stop && hit;
  assign thresh_hit   = count_en && ((cnt_reg + 1'b1) == thresh_reg);

  seq_pattern_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk      (clk),
    .arst     (arst),
    .clr      (state_reg == ARM),
    .shift_en ((state_reg == RUN) && bus.in_valid),
    .in       (bus.in),
    .pattern  (pattern_reg),
    .len      (len_reg),
    .hit      (hit)
  );

  always_comb begin
    state_next   = state_reg;
    cfg_err_next = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          if (cfg_ok) state_next = ARM;
          else        cfg_err_next = 1'b1;
        end
      end
      ARM:     state_next = RUN;
      RUN: begin
        if (bus.stop)       state_next = IDLE;
        else if (thresh_hit) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg   <= IDLE;
      pattern_reg <= '0;
      len_reg     <= '0;
      thresh_reg  <= '0;
      cnt_reg     <= '0;
      match_reg   <= 1'b0;
      cfg_err_reg <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cfg_err_reg <= cfg_err_next;
      match_reg   <= count_en;
      if (bus.cfg_we && idle_or_done) begin
        pattern_reg <= bus.cfg_pattern;
        len_reg     <= bus.cfg_len;
        thresh_reg  <= bus.cfg_thresh;
      end
      if (state_reg == ARM)  cnt_reg <= '0;
      else if (count_en)     cnt_reg <= cnt_reg + 1'b1;
      if (thresh_hit)        irq_reg <= 1'b1;
      else if (bus.irq_clr)  irq_reg <= 1'b0;
    end
  end

  assign bus.match     = match_reg;
  assign bus.busy      = (state_reg == ARM) || (state_reg == RUN);
  assign bus.done      = (state_reg == DONE);
  assign bus.cfg_err   = cfg_err_reg;
  assign bus.match_cnt = cnt_reg;
  assign bus.irq       = irq_reg;

endmodule
